tl_ul_mem_responder: RTL
========================

// Module: tl_ul_mem_responder
// PURPOSE
//  TileLink-UL responder (manager side) backed by a small synchronous RAM.
//  It terminates the A/D channel pair that a bridge master port drives, so
//  a punch-through master can be exercised in simulation without an SoC bus.
//  It accepts one single-beat Get/PutFull/PutPartial at a time and returns
//  AccessAck or AccessAckData on D.
// PARAMETERS
//  ADDR_W      32          A-channel address width
//  DATA_W      64          data width; mask width is DATA_W/8
//  SRC_W       2           source ID width
//  SIZE_W      4           size field width
//  DEPTH_LOG2  8           RAM depth, 2**DEPTH_LOG2 words of DATA_W bits
//  BASE_ADDR   32'h1000_0000  byte base address of the RAM window
//  RESP_DELAY  3           extra D-valid wait cycles; used only with TL_RESP_DELAY_EN
// PORTS
//  clock           in   1          single clock
//  reset           in   1          synchronous, active-high
//  a_valid         in   1          A request valid
//  a_ready         out  1          A request ready
//  a_opcode        in   3          0=PutFull, 1=PutPartial, 4=Get
//  a_param         in   3          ignored
//  a_size          in   SIZE_W     log2 bytes; must be <= log2(DATA_W/8)
//  a_source        in   SRC_W      echoed on d_source
//  a_address       in   ADDR_W     byte address
//  a_mask          in   DATA_W/8   byte lane enables
//  a_data          in   DATA_W     write data
//  a_corrupt       in   1          nonzero -> write suppressed, no denial
//  d_valid         out  1          D response valid
//  d_ready         in   1          D response ready
//  d_opcode        out  3          0=AccessAck, 1=AccessAckData
//  d_param         out  2          always 0
//  d_size          out  SIZE_W     echo of a_size
//  d_source        out  SRC_W      echo of a_source
//  d_sink          out  3          always 0
//  d_denied        out  1          request rejected
//  d_data          out  DATA_W     read data; 0 when not AccessAckData or denied
//  d_corrupt       out  1          equals d_denied on AccessAckData, else 0
// BEHAVIOUR
//  - Reset: state=IDLE, a_ready=1, d_valid=0, all d_* fields=0. RAM contents are not reset.
//  - FSM IDLE -> RESP when a_valid&&a_ready. RESP -> IDLE when d_valid&&d_ready.
//    With the optional feature, the FSM is IDLE -> WAIT -> RESP.
//  - a_ready = (state==IDLE). It is a registered output, so at most one request is
//    outstanding and no A is accepted in the cycle D fires. Throughput is 1 op / 2 cycles.
//  - Word index = (a_address-BASE_ADDR) >> log2(DATA_W/8), taking the low DEPTH_LOG2 bits.
//  - Denied when any of these holds: address is outside [BASE, BASE + 2**DEPTH_LOG2*DATA_W/8);
//    a_size > log2(DATA_W/8); opcode is not in {0,1,4}; address is misaligned to a_size.
//  - Denied requests: no RAM write; d_opcode = Get?1:0; d_denied=1; d_data=0.
//  - Put: on the acceptance edge, write the RAM byte lanes where a_mask=1. PutFull
//    uses the mask exactly as given (no mask check). d_opcode=0 next cycle.
//  - Get: on the acceptance edge, register the RAM word. d_data holds the full word
//    (the master selects lanes). A Get that follows a Put returns the new data.
//  - Latency: d_valid rises the cycle after acceptance, 1 cycle after the A fire.
//  - Hold: once d_valid=1, all d_* fields stay stable until d_ready is sampled 1.
//  - a_valid deasserting before acceptance has no effect (no state change).
//  - Reset mid-response drops the response: d_valid=0 the next cycle and any
//    pending WAIT count is cleared. A RAM write already committed stays committed.
// CONFIGURATION
//  TL_RESP_DELAY_EN defined: after acceptance the FSM enters WAIT, and a counter
//    loads RESP_DELAY and decrements each cycle. The FSM moves to RESP when the
//    count reaches 0, so d_valid rises RESP_DELAY+1 cycles after the A fire.
//    RESP_DELAY=0 behaves identically to the undefined case. a_ready stays 0
//    throughout WAIT.
//  TL_RESP_DELAY_EN undefined: there is no WAIT state and no counter logic.
//    Latency is fixed at 1 cycle.
// TESTING
//  1. Reset, then PutFull addr=BASE+0x8, mask=FF, data=DEAD_BEEF_0123_4567
//     -> next cycle d_valid=1, d_opcode=0, d_denied=0, d_source echoed.
//  2. Get addr=BASE+0x8, size=3 -> d_opcode=1, d_data=DEAD_BEEF_0123_4567, d_corrupt=0.
//  3. PutPartial addr=BASE+0x8, mask=0x0F, data=0 -> a following Get returns
//     DEAD_BEEF_0000_0000.
//  4. Get addr=BASE+0x800 (out of range, DEPTH_LOG2=8) -> d_denied=1, d_corrupt=1,
//     d_data=0, RAM unchanged.
//  5. Hold d_ready=0 for 5 cycles after a response -> d_* stable and a_ready=0
//     throughout; a_ready=1 the cycle after d_ready=1.
//  6. With TL_RESP_DELAY_EN and RESP_DELAY=3, Get -> d_valid 4 cycles after the
//     A fire. Assert reset during WAIT -> no response is issued.

Source files
------------

// File: rtl/tl_ul_mem_responder_if.sv
// TileLink-UL A/D channel pair between a bridge master port and a manager.
// Handshake: a beat transfers on a rising clock edge where valid and ready are
// both 1; a sender holds valid and all payload fields stable until that edge.
interface tl_ul_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 2,
    parameter int SIZE_W = 4
);
    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_opcode;
    logic [2:0]            a_param;
    logic [SIZE_W-1:0]     a_size;
    logic [SRC_W-1:0]      a_source;
    logic [ADDR_W-1:0]     a_address;
    logic [DATA_W/8-1:0]   a_mask;
    logic [DATA_W-1:0]     a_data;
    logic                  a_corrupt;

    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_opcode;
    logic [1:0]            d_param;
    logic [SIZE_W-1:0]     d_size;
    logic [SRC_W-1:0]      d_source;
    logic [2:0]            d_sink;
    logic                  d_denied;
    logic [DATA_W-1:0]     d_data;
    logic                  d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_corrupt, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_data, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_corrupt, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_data, d_corrupt
    );
endinterface

// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL manager backed by a small synchronous RAM. Accepts one
// single-beat Get/PutFull/PutPartial at a time and answers on D.
// Optional feature macro: TL_RESP_DELAY_EN adds a WAIT state that delays
// d_valid by RESP_DELAY extra cycles.
module tl_ul_mem_responder #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 64,
    parameter int                SRC_W      = 2,
    parameter int                SIZE_W     = 4,
    parameter int                DEPTH_LOG2 = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int                RESP_DELAY = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    tl_ul_mem_responder_if.slave   bus,
    output logic [1:0]             dbg_state_o
);
    localparam int LANES     = DATA_W / 8;
    localparam int LANE_LOG2 = $clog2(LANES);
    localparam int DEPTH     = 2 ** DEPTH_LOG2;

`ifdef TL_RESP_DELAY_EN
    localparam int CNT_W = (RESP_DELAY > 1) ? $clog2(RESP_DELAY + 1) : 1;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd1, ST_WAIT = 2'd2} state_e;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int unused_resp_delay = RESP_DELAY;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd1} state_e;
`endif

    state_e                  state_q, state_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic [2:0]              d_opcode_q;
    logic [SIZE_W-1:0]       d_size_q;
    logic [SRC_W-1:0]        d_source_q;
    logic                    d_denied_q;
    logic [DATA_W-1:0]       d_data_q;
    logic                    d_corrupt_q;

    logic [ADDR_W-1:0]       offset;
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic                    is_get, op_bad, size_bad, range_bad, misalign, denied;
    logic                    a_fire, d_fire, wr_en;
    logic                    unused_bits;

    assign unused_bits = ^bus.a_param;

    // Decode the A beat: window check, size/opcode legality and alignment.
    always_comb begin
        offset    = bus.a_address - BASE_ADDR;
        word_idx  = offset[LANE_LOG2 +: DEPTH_LOG2];
        is_get    = (bus.a_opcode == 3'd4);
        op_bad    = !((bus.a_opcode == 3'd0) || (bus.a_opcode == 3'd1) || is_get);
        size_bad  = (bus.a_size > SIZE_W'(LANE_LOG2));
        range_bad = (bus.a_address < BASE_ADDR) ||
                    ((offset >> (DEPTH_LOG2 + LANE_LOG2)) != '0);
        misalign  = 1'b0;
        for (int i = 0; i < LANE_LOG2; i++) begin
            if (bus.a_address[i] && (i < int'(bus.a_size))) misalign = 1'b1;
        end
        denied    = op_bad || size_bad || range_bad || misalign;
    end

    assign bus.a_ready = (state_q == ST_IDLE);
    assign bus.d_valid = (state_q == ST_RESP);
    assign a_fire      = bus.a_valid && bus.a_ready;
    assign d_fire      = bus.d_valid && bus.d_ready;
    // Corrupt Puts are acknowledged normally but never touch the RAM.
    assign wr_en       = a_fire && !denied && !is_get && !bus.a_corrupt && !reset;

    // Next-state logic: one request in flight, optional delay before D.
    always_comb begin
        state_d = state_q;
`ifdef TL_RESP_DELAY_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
`ifdef TL_RESP_DELAY_EN
                    if (RESP_DELAY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(RESP_DELAY);
                    end
`else
                    state_d = ST_RESP;
`endif
                end
            end
`ifdef TL_RESP_DELAY_EN
            ST_WAIT: begin
                // Leave WAIT on the same edge the count reaches zero.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (d_fire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State (and delay counter) register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
`ifdef TL_RESP_DELAY_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef TL_RESP_DELAY_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Capture the whole D beat at acceptance so it is stable while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_data_q    <= '0;
            d_corrupt_q <= 1'b0;
        end else if (a_fire) begin
            d_opcode_q  <= is_get ? 3'd1 : 3'd0;
            d_size_q    <= bus.a_size;
            d_source_q  <= bus.a_source;
            d_denied_q  <= denied;
            d_data_q    <= (is_get && !denied) ? mem_q[word_idx] : '0;
            d_corrupt_q <= is_get && denied;
        end
    end

    // Byte-lane RAM write; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (bus.a_mask[b]) mem_q[word_idx][b*8 +: 8] <= bus.a_data[b*8 +: 8];
            end
        end
    end

    assign bus.d_opcode  = d_opcode_q;
    assign bus.d_param   = 2'd0;
    assign bus.d_size    = d_size_q;
    assign bus.d_source  = d_source_q;
    assign bus.d_sink    = 3'd0;
    assign bus.d_denied  = d_denied_q;
    assign bus.d_data    = d_data_q;
    assign bus.d_corrupt = d_corrupt_q;
    assign dbg_state_o   = state_q;
endmodule
